// File: rtl/ss_chan_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ss_chan_buf_if                                            |
// | Brief    : Handshake bundle between the Wishbone DMA engine (ss_*)   |
// |            and the per-channel processing module (m_*).              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ss_chan_buf_if #(
  parameter int DW = 64,
  parameter int AW = 9
);
  // source FIFO: Wishbone writes, processing module reads
  logic          ss_xfer0;
  logic          ss_last0;
  logic [DW-1:0] ss_dat0;
  logic          ss_stop0;
  logic          ss_start0;
  logic          ss_end0;
  logic          m_src_getn;
  logic [DW-1:0] m_src;
  logic          m_src_last;
  logic          m_src_empty;
  logic          m_src_almost_empty;
  logic [AW:0]   m_src_cnt;

  // destination FIFO: processing module writes, Wishbone reads
  logic          m_dst_putn;
  logic [DW-1:0] m_dst;
  logic          m_dst_last;
  logic          m_dst_full;
  logic          m_dst_almost_full;
  logic [AW:0]   m_dst_cnt;
  logic          ss_xfer1;
  logic [DW-1:0] ss_dat1;
  logic          ss_stop1;
  logic          ss_start1;
  logic          ss_end1;

  // sticky {dst_udf, dst_ovf, src_udf, src_ovf}
  logic [3:0]    err_flags;

  // the channel buffer itself
  modport slave (
    input  ss_xfer0, ss_last0, ss_dat0, m_src_getn,
           m_dst_putn, m_dst, m_dst_last, ss_xfer1,
    output ss_stop0, ss_start0, ss_end0,
           m_src, m_src_last, m_src_empty, m_src_almost_empty, m_src_cnt,
           m_dst_full, m_dst_almost_full, m_dst_cnt,
           ss_dat1, ss_stop1, ss_start1, ss_end1, err_flags
  );

  // the environment driving the buffer
  modport master (
    output ss_xfer0, ss_last0, ss_dat0, m_src_getn,
           m_dst_putn, m_dst, m_dst_last, ss_xfer1,
    input  ss_stop0, ss_start0, ss_end0,
           m_src, m_src_last, m_src_empty, m_src_almost_empty, m_src_cnt,
           m_dst_full, m_dst_almost_full, m_dst_cnt,
           ss_dat1, ss_stop1, ss_start1, ss_end1, err_flags
  );
endinterface
`default_nettype wire

// File: rtl/ss_chan_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ss_chan_buf                                               |
// | Brief    : DMA channel buffer - one first-word-fall-through source   |
// |            FIFO and one destination FIFO with occupancy, watermark,  |
// |            last-word tracking and sticky error flags.                |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ss_chan_buf #(
  parameter int DW        = 64,
  parameter int AW        = 9,
  parameter int AE_MARGIN = 4,
  parameter int AF_MARGIN = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         m_reset,
  ss_chan_buf_if.slave bus
);

  localparam int          c_depth = 1 << AW;
  localparam logic [AW:0] c_full  = (AW+1)'(c_depth);
  localparam logic [AW:0] c_half  = (AW+1)'(c_depth / 2);
  localparam logic [AW:0] c_ae    = (AW+1)'(AE_MARGIN);
  localparam logic [AW:0] c_af    = (AW+1)'(c_depth - AF_MARGIN);

  // storage: {last, data} per entry; never cleared, pointers define validity
  logic [DW:0] r_src_mem [0:c_depth-1];
  logic [DW:0] r_dst_mem [0:c_depth-1];

  logic [AW:0] r_src_wptr, r_src_rptr;
  logic [AW:0] r_dst_wptr, r_dst_rptr;
  logic [AW:0] r_dst_last_cnt;
  logic        r_end0;
  logic [3:0]  r_err;

  logic [AW:0] w_src_cnt, w_dst_cnt;
  logic        w_src_full, w_src_empty, w_dst_full, w_dst_empty;
  logic        w_src_push_req, w_src_pop_req, w_src_push, w_src_pop;
  logic        w_dst_push_req, w_dst_pop_req, w_dst_push, w_dst_pop;
  logic [DW:0] w_src_head, w_dst_head;
  logic        w_last_inc, w_last_dec;

  // pointer difference wraps naturally thanks to the extra MSB
  assign w_src_cnt   = r_src_wptr - r_src_rptr;
  assign w_dst_cnt   = r_dst_wptr - r_dst_rptr;
  assign w_src_full  = (w_src_cnt == c_full);
  assign w_src_empty = (w_src_cnt == '0);
  assign w_dst_full  = (w_dst_cnt == c_full);
  assign w_dst_empty = (w_dst_cnt == '0);

  // acceptance depends only on the pre-edge count, so a pop never makes
  // room for a push issued in the same cycle (and vice versa)
  assign w_src_push_req = bus.ss_xfer0;
  assign w_src_pop_req  = !bus.m_src_getn;
  assign w_dst_push_req = !bus.m_dst_putn;
  assign w_dst_pop_req  = bus.ss_xfer1;
  assign w_src_push     = w_src_push_req && !w_src_full;
  assign w_src_pop      = w_src_pop_req  && !w_src_empty;
  assign w_dst_push     = w_dst_push_req && !w_dst_full;
  assign w_dst_pop      = w_dst_pop_req  && !w_dst_empty;

  // first-word-fall-through heads
  assign w_src_head = r_src_mem[r_src_rptr[AW-1:0]];
  assign w_dst_head = r_dst_mem[r_dst_rptr[AW-1:0]];

  assign w_last_inc = w_dst_push && bus.m_dst_last;
  assign w_last_dec = w_dst_pop  && w_dst_head[DW];

  // array writes; a channel clear suppresses the push
  always_ff @(posedge wb_clk_i) begin
    if (w_src_push && !m_reset)
      r_src_mem[r_src_wptr[AW-1:0]] <= {bus.ss_last0, bus.ss_dat0};
    if (w_dst_push && !m_reset)
      r_dst_mem[r_dst_wptr[AW-1:0]] <= {bus.m_dst_last, bus.m_dst};
  end

  // pointers, last-word count, end marker and sticky error flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_src_wptr     <= '0;
      r_src_rptr     <= '0;
      r_dst_wptr     <= '0;
      r_dst_rptr     <= '0;
      r_dst_last_cnt <= '0;
      r_end0         <= 1'b0;
      r_err          <= '0;
    end else if (m_reset) begin
      r_src_wptr     <= '0;
      r_src_rptr     <= '0;
      r_dst_wptr     <= '0;
      r_dst_rptr     <= '0;
      r_dst_last_cnt <= '0;
      r_end0         <= 1'b0;
      r_err          <= '0;
    end else begin
      if (w_src_push) r_src_wptr <= r_src_wptr + 1'b1;
      if (w_src_pop)  r_src_rptr <= r_src_rptr + 1'b1;
      if (w_dst_push) r_dst_wptr <= r_dst_wptr + 1'b1;
      if (w_dst_pop)  r_dst_rptr <= r_dst_rptr + 1'b1;
      if (w_last_inc && !w_last_dec)
        r_dst_last_cnt <= r_dst_last_cnt + 1'b1;
      else if (w_last_dec && !w_last_inc)
        r_dst_last_cnt <= r_dst_last_cnt - 1'b1;
      if (w_src_push && bus.ss_last0) r_end0 <= 1'b1;
      r_err <= r_err | {w_dst_pop_req  && w_dst_empty,
                        w_dst_push_req && w_dst_full,
                        w_src_pop_req  && w_src_empty,
                        w_src_push_req && w_src_full};
    end
  end

  // source side outputs
  assign bus.m_src              = w_src_head[DW-1:0];
  assign bus.m_src_last         = w_src_head[DW];
  assign bus.m_src_empty        = w_src_empty;
  assign bus.m_src_almost_empty = (w_src_cnt <= c_ae);
  assign bus.m_src_cnt          = w_src_cnt;
  assign bus.ss_stop0           = (w_src_cnt >= c_af);
  assign bus.ss_start0          = (w_src_cnt < c_half);
  assign bus.ss_end0            = r_end0;

  // destination side outputs
  assign bus.m_dst_full        = w_dst_full;
  assign bus.m_dst_almost_full = (w_dst_cnt >= c_af);
  assign bus.m_dst_cnt         = w_dst_cnt;
  assign bus.ss_dat1           = w_dst_head[DW-1:0];
  assign bus.ss_start1         = (w_dst_cnt >= c_half) || (r_dst_last_cnt != '0);
  assign bus.ss_stop1          = (w_dst_cnt <= c_ae) && (r_dst_last_cnt == '0);
  assign bus.ss_end1           = !w_dst_empty && w_dst_head[DW];
  assign bus.err_flags         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ss_chan_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ss_chan_buf                                            |
// | Brief    : Self-checking bench for ss_chan_buf; directed scenarios   |
// |            plus randomized traffic against a queue-based model.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ss_chan_buf #(
  parameter int DW = 64,
  parameter int AW = 9,
  parameter int AE = 4,
  parameter int AF = 4
);
  localparam int D = 1 << AW;
  localparam logic [AW+5:0] c_rst_src = {1'b1, 1'b1, {(AW+1){1'b0}}, 1'b0, 1'b1, 1'b0};
  localparam logic [AW+5:0] c_rst_dst = {1'b0, 1'b0, {(AW+1){1'b0}}, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ss_chan_buf_if #(.DW(DW), .AW(AW)) bus ();

  ss_chan_buf #(.DW(DW), .AW(AW), .AE_MARGIN(AE), .AF_MARGIN(AF)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m_reset  (m_reset),
    .bus      (bus.slave)
  );

  // reference model: plain queues of {last, data}
  logic [DW:0] src_q[$];
  logic [DW:0] dst_q[$];
  logic [3:0]  m_err = '0;
  logic        m_end0 = 1'b0;

  logic [AW+5:0] act_src, act_dst;
  assign act_src = {bus.m_src_empty, bus.m_src_almost_empty, bus.m_src_cnt,
                    bus.ss_stop0, bus.ss_start0, bus.ss_end0};
  assign act_dst = {bus.m_dst_full, bus.m_dst_almost_full, bus.m_dst_cnt,
                    bus.ss_start1, bus.ss_stop1, bus.ss_end1};

  function automatic logic [AW+5:0] exp_src();
    int n = src_q.size();
    return {n == 0, n <= AE, (AW+1)'(n), n >= D - AF, n < D / 2, m_end0};
  endfunction

  function automatic logic [AW+5:0] exp_dst();
    int n = dst_q.size();
    int nl = 0;
    foreach (dst_q[k]) if (dst_q[k][DW]) nl++;
    return {n == D, n >= D - AF, (AW+1)'(n), (n >= D / 2) || (nl != 0),
            (n <= AE) && (nl == 0), (n != 0) && dst_q[0][DW]};
  endfunction

  task automatic drive_idle();
    bus.ss_xfer0   = 1'b0;
    bus.ss_last0   = 1'b0;
    bus.ss_dat0    = '0;
    bus.m_src_getn = 1'b1;
    bus.m_dst_putn = 1'b1;
    bus.m_dst      = '0;
    bus.m_dst_last = 1'b0;
    bus.ss_xfer1   = 1'b0;
    m_reset        = 1'b0;
  endtask

  // one clock edge with the currently driven inputs; model follows the rules
  task automatic tick();
    logic sp, sl, spop, dp, dl, dpop, mr;
    logic [DW-1:0] sd, dd;
    logic s_full, s_emp, d_full, d_emp;
    sp = bus.ss_xfer0; sl = bus.ss_last0; sd = bus.ss_dat0; spop = !bus.m_src_getn;
    dp = !bus.m_dst_putn; dl = bus.m_dst_last; dd = bus.m_dst; dpop = bus.ss_xfer1;
    mr = m_reset;
    @(posedge clk);
    if (mr || !rst_n) begin
      src_q.delete(); dst_q.delete(); m_err = '0; m_end0 = 1'b0;
    end else begin
      s_full = (src_q.size() == D); s_emp = (src_q.size() == 0);
      d_full = (dst_q.size() == D); d_emp = (dst_q.size() == 0);
      if (sp && s_full)   m_err[0] = 1'b1;
      if (spop && s_emp)  m_err[1] = 1'b1;
      if (dp && d_full)   m_err[2] = 1'b1;
      if (dpop && d_emp)  m_err[3] = 1'b1;
      if (spop && !s_emp) void'(src_q.pop_front());
      if (sp && !s_full) begin src_q.push_back({sl, sd}); if (sl) m_end0 = 1'b1; end
      if (dpop && !d_emp) void'(dst_q.pop_front());
      if (dp && !d_full)  dst_q.push_back({dl, dd});
    end
    #1;
  endtask

  task automatic chan_clear();
    drive_idle();
    m_reset = 1'b1;
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    n_tests++; if (act_src !== c_rst_src) begin n_fail++; $display("FAIL reset_src got %h exp %h", act_src, c_rst_src); end
    n_tests++; if (act_dst !== c_rst_dst) begin n_fail++; $display("FAIL reset_dst got %h exp %h", act_dst, c_rst_dst); end
    n_tests++; if (bus.err_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_err got %b exp 0000", bus.err_flags); end
  endtask

  task automatic test_src_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    chan_clear();
    for (int i = 0; i < 3; i++) begin
      bus.ss_xfer0 = 1'b1; bus.ss_dat0 = DW'(vals[i]); bus.ss_last0 = (i == 2);
      tick();
    end
    drive_idle();
    n_tests++; if (bus.m_src_cnt !== 10'd3 || bus.ss_end0 !== 1'b1) begin
      n_fail++; $display("FAIL src_basic_cnt_end got cnt=%0d end=%b exp cnt=3 end=1", bus.m_src_cnt, bus.ss_end0);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (bus.m_src !== DW'(vals[i]) || bus.m_src_last !== (i == 2)) begin
        n_fail++; $display("FAIL src_basic_pop%0d got %h/%b exp %h/%b", i, bus.m_src, bus.m_src_last, vals[i], i == 2);
      end
      bus.m_src_getn = 1'b0; tick(); drive_idle();
    end
    n_tests++; if (bus.m_src_empty !== 1'b1) begin n_fail++; $display("FAIL src_basic_empty got %b exp 1", bus.m_src_empty); end
  endtask

  task automatic test_src_fill();
    logic [DW-1:0] first;
    chan_clear();
    for (int i = 0; i < D; i++) begin
      bus.ss_xfer0 = 1'b1; bus.ss_dat0 = {$urandom, $urandom};
      if (i == 0) first = bus.ss_dat0;
      tick();
      n_tests++; if (bus.ss_stop0 !== (i + 1 >= D - AF)) begin
        n_fail++; $display("FAIL src_fill_stop0 cnt=%0d got %b exp %b", i + 1, bus.ss_stop0, i + 1 >= D - AF);
      end
    end
    n_tests++; if (bus.m_src_cnt !== 10'd512 || bus.err_flags !== 4'b0000) begin
      n_fail++; $display("FAIL src_full got cnt=%0d err=%b exp 512/0000", bus.m_src_cnt, bus.err_flags);
    end
    bus.ss_dat0 = {$urandom, $urandom}; tick(); drive_idle();
    n_tests++; if (bus.m_src_cnt !== 10'd512 || bus.err_flags !== 4'b0001) begin
      n_fail++; $display("FAIL src_ovf got cnt=%0d err=%b exp 512/0001", bus.m_src_cnt, bus.err_flags);
    end
    n_tests++; if (bus.m_src !== first) begin n_fail++; $display("FAIL src_ovf_head got %h exp %h", bus.m_src, first); end
  endtask

  task automatic test_dst_underflow();
    chan_clear();
    bus.ss_xfer1 = 1'b1; tick(); drive_idle();
    n_tests++; if (bus.err_flags !== 4'b1000 || bus.m_dst_cnt !== 10'd0) begin
      n_fail++; $display("FAIL dst_udf got err=%b cnt=%0d exp 1000/0", bus.err_flags, bus.m_dst_cnt);
    end
  endtask

  task automatic test_simul_empty();
    chan_clear();
    bus.m_dst_putn = 1'b0; bus.m_dst = 64'hA5A5; bus.ss_xfer1 = 1'b1; tick(); drive_idle();
    n_tests++; if (bus.err_flags !== 4'b1000 || bus.m_dst_cnt !== 10'd1 || bus.ss_dat1 !== 64'hA5A5) begin
      n_fail++; $display("FAIL simul_empty got err=%b cnt=%0d dat=%h exp 1000/1/a5a5", bus.err_flags, bus.m_dst_cnt, bus.ss_dat1);
    end
  endtask

  task automatic test_dst_last();
    chan_clear();
    bus.m_dst_putn = 1'b0; bus.m_dst = 64'h1111; bus.m_dst_last = 1'b0; tick();
    bus.m_dst = 64'h2222; bus.m_dst_last = 1'b1; tick(); drive_idle();
    n_tests++; if ({bus.ss_start1, bus.ss_stop1, bus.ss_end1} !== 3'b100 || bus.ss_dat1 !== 64'h1111) begin
      n_fail++; $display("FAIL dst_last_pushed got st/sp/end=%b%b%b dat=%h exp 100/1111", bus.ss_start1, bus.ss_stop1, bus.ss_end1, bus.ss_dat1);
    end
    bus.ss_xfer1 = 1'b1; tick(); drive_idle();
    n_tests++; if ({bus.ss_start1, bus.ss_stop1, bus.ss_end1} !== 3'b101 || bus.ss_dat1 !== 64'h2222) begin
      n_fail++; $display("FAIL dst_last_pop1 got st/sp/end=%b%b%b dat=%h exp 101/2222", bus.ss_start1, bus.ss_stop1, bus.ss_end1, bus.ss_dat1);
    end
    bus.ss_xfer1 = 1'b1; tick(); drive_idle();
    n_tests++; if ({bus.ss_start1, bus.ss_stop1, bus.ss_end1} !== 3'b010) begin
      n_fail++; $display("FAIL dst_last_pop2 got st/sp/end=%b%b%b exp 010", bus.ss_start1, bus.ss_stop1, bus.ss_end1);
    end
  endtask

  task automatic test_m_reset();
    chan_clear();
    bus.m_src_getn = 1'b0; tick(); drive_idle();
    for (int i = 0; i < 300; i++) begin
      bus.m_dst_putn = 1'b0; bus.m_dst = {$urandom, $urandom}; tick();
    end
    drive_idle();
    n_tests++; if (bus.m_dst_cnt !== 10'd300 || bus.ss_start1 !== 1'b1 || bus.err_flags !== 4'b0010) begin
      n_fail++; $display("FAIL mreset_pre got cnt=%0d start1=%b err=%b exp 300/1/0010", bus.m_dst_cnt, bus.ss_start1, bus.err_flags);
    end
    bus.m_dst_putn = 1'b0; bus.m_dst = 64'h77; m_reset = 1'b1; tick(); drive_idle();
    n_tests++; if (act_dst !== c_rst_dst || bus.err_flags !== 4'b0000) begin
      n_fail++; $display("FAIL mreset_post got dst=%h err=%b exp %h/0000", act_dst, bus.err_flags, c_rst_dst);
    end
  endtask

  task automatic test_async_reset();
    chan_clear();
    for (int i = 0; i < 6; i++) begin
      bus.ss_xfer0 = 1'b1; bus.ss_last0 = (i == 2); bus.ss_dat0 = {$urandom, $urandom};
      bus.m_dst_putn = 1'b0; bus.m_dst = {$urandom, $urandom}; bus.m_dst_last = 1'b1;
      bus.ss_xfer1 = (i == 0);
      tick();
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (act_src !== c_rst_src) begin n_fail++; $display("FAIL async_src got %h exp %h", act_src, c_rst_src); end
    n_tests++; if (act_dst !== c_rst_dst) begin n_fail++; $display("FAIL async_dst got %h exp %h", act_dst, c_rst_dst); end
    n_tests++; if (bus.err_flags !== 4'b0000) begin n_fail++; $display("FAIL async_err got %b exp 0000", bus.err_flags); end
    src_q.delete(); dst_q.delete(); m_err = '0; m_end0 = 1'b0;
    drive_idle();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (act_src !== c_rst_src || act_dst !== c_rst_dst) begin
      n_fail++; $display("FAIL async_release got %h/%h exp %h/%h", act_src, act_dst, c_rst_src, c_rst_dst);
    end
  endtask

  task automatic test_random();
    int push_pct, pop_pct;
    chan_clear();
    for (int i = 0; i < 3000; i++) begin
      case (i / 1000)
        0:       begin push_pct = 80; pop_pct = 20; end
        1:       begin push_pct = 20; pop_pct = 80; end
        default: begin push_pct = 50; pop_pct = 50; end
      endcase
      bus.ss_xfer0   = ($urandom_range(99) < push_pct);
      bus.ss_last0   = ($urandom_range(7) == 0);
      bus.ss_dat0    = {$urandom, $urandom};
      bus.m_src_getn = !($urandom_range(99) < pop_pct);
      bus.m_dst_putn = !($urandom_range(99) < push_pct);
      bus.m_dst_last = ($urandom_range(7) == 0);
      bus.m_dst      = {$urandom, $urandom};
      bus.ss_xfer1   = ($urandom_range(99) < pop_pct);
      m_reset        = (i >= 2000) && ($urandom_range(199) == 0);
      tick();
      n_tests++; if (act_src !== exp_src()) begin n_fail++; $display("FAIL rnd_src cyc %0d got %h exp %h", i, act_src, exp_src()); end
      n_tests++; if (act_dst !== exp_dst()) begin n_fail++; $display("FAIL rnd_dst cyc %0d got %h exp %h", i, act_dst, exp_dst()); end
      n_tests++; if (bus.err_flags !== m_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b exp %b", i, bus.err_flags, m_err); end
      if (src_q.size() != 0) begin
        n_tests++; if ({bus.m_src_last, bus.m_src} !== src_q[0]) begin
          n_fail++; $display("FAIL rnd_src_head cyc %0d got %h exp %h", i, {bus.m_src_last, bus.m_src}, src_q[0]);
        end
      end
      if (dst_q.size() != 0) begin
        n_tests++; if (bus.ss_dat1 !== dst_q[0][DW-1:0]) begin
          n_fail++; $display("FAIL rnd_dst_head cyc %0d got %h exp %h", i, bus.ss_dat1, dst_q[0][DW-1:0]);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_src_basic();
    test_src_fill();
    test_dst_underflow();
    test_simul_empty();
    test_dst_last();
    test_m_reset();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
